// File: rtl/dpram_arb_pkg.sv
// Shared types for the port-B arbiter of the dual-port video/system RAM.
//   requester_t : which client owns an access (video scan-out or loader/DMA).
//   arb_tag_t   : per-access tag carried down the issue/return pipeline.
//   DATA_W_DEF / ADDR_W_DEF : default RAM word and address widths.
package dpram_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 14;

  typedef enum logic {
    REQ_VIDEO  = 1'b0,
    REQ_LOADER = 1'b1
  } requester_t;

  typedef struct packed {
    logic       valid;
    logic       is_read;
    requester_t who;
  } arb_tag_t;

  localparam arb_tag_t TAG_IDLE = '{valid: 1'b0, is_read: 1'b0, who: REQ_VIDEO};

endpackage

// File: rtl/dpram_arb_grant.sv
// Grant logic for the port-B arbiter.
// Video (requester 0) has fixed priority; the loader (requester 1) is forced
// to win once it has been pending and refused for max_wait_g cycles.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   req0, req1   : requests from video and loader
//   ack0, ack1   : combinational accepts; never both high, both 0 in reset
module dpram_arb_grant #(
  parameter int max_wait_g = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic ack0,
  output logic ack1
);

  localparam logic [7:0] MAX_WAIT = 8'(max_wait_g);

  logic [7:0] wait_cnt;
  logic       force1;
  logic       win1;

  always_comb begin
    force1 = (wait_cnt == MAX_WAIT);
    win1   = req1 && (!req0 || force1);
    ack1   = 1'b0;
    ack0   = 1'b0;
    if (!reset) begin
      ack1 = win1;
      ack0 = req0 && !win1;
    end
  end

  // Counts consecutive refused cycles of a pending loader request; it stops
  // at the limit so force1 stays asserted until the loader is served.
  always_ff @(posedge clock) begin
    if (reset || !req1 || ack1) begin
      wait_cnt <= 8'd0;
    end else if (!force1) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Arbiter sharing port B of the dual-port video/system RAM between the video
// scan-out fetcher (requester 0, read-only, high priority) and the ROM/tape
// loader / debug DMA (requester 1, read/write). One access accepted per clock;
// read data returns two clocks after the acceptance edge, in issue order.
// Ports:
//   clock, reset                    : system clock, synchronous active-high reset
//   req0, addr0, ack0               : video request/address/accept
//   rvalid0, rdata0                 : video read return (one-cycle pulse)
//   req1, we1, addr1, wdata1, ack1  : loader request/write-enable/address/data/accept
//   rvalid1, rdata1                 : loader read return (reads only)
//   ram_cs_b, ram_wren_b,
//   ram_address_b, ram_data_b       : registered port-B strobes, address, write data
//   ram_q_b                         : port-B read data, one clock after the address
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int data_width_g = DATA_W_DEF,
  parameter int addr_width_g = ADDR_W_DEF,
  parameter int max_wait_g   = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0,
  input  logic [addr_width_g-1:0] addr0,
  output logic                    ack0,
  output logic                    rvalid0,
  output logic [data_width_g-1:0] rdata0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [addr_width_g-1:0] addr1,
  input  logic [data_width_g-1:0] wdata1,
  output logic                    ack1,
  output logic                    rvalid1,
  output logic [data_width_g-1:0] rdata1,
  output logic                    ram_cs_b,
  output logic                    ram_wren_b,
  output logic [addr_width_g-1:0] ram_address_b,
  output logic [data_width_g-1:0] ram_data_b,
  input  logic [data_width_g-1:0] ram_q_b
);

  arb_tag_t tag_p0;
  arb_tag_t tag_p1;
  arb_tag_t tag_p2;
  logic     ret0;
  logic     ret1;

  dpram_arb_grant #(
    .max_wait_g(max_wait_g)
  ) u_grant (
    .clock(clock),
    .reset(reset),
    .req0 (req0),
    .req1 (req1),
    .ack0 (ack0),
    .ack1 (ack1)
  );

  // Stage p0: tag of the access being accepted this cycle.
  always_comb begin
    tag_p0         = TAG_IDLE;
    tag_p0.valid   = ack0 || ack1;
    tag_p0.is_read = ack0 || (ack1 && !we1);
    tag_p0.who     = ack1 ? REQ_LOADER : REQ_VIDEO;
  end

  // Stage p2 -> return: a valid read tag routes ram_q_b to its owner.
  always_comb begin
    ret0 = tag_p2.valid && tag_p2.is_read && (tag_p2.who == REQ_VIDEO);
    ret1 = tag_p2.valid && tag_p2.is_read && (tag_p2.who == REQ_LOADER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_cs_b      <= 1'b0;
      ram_wren_b    <= 1'b0;
      ram_address_b <= '0;
      ram_data_b    <= '0;
      tag_p1        <= TAG_IDLE;
      tag_p2        <= TAG_IDLE;
      rvalid0       <= 1'b0;
      rvalid1       <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      // Stage p0 -> p1: issue to port B; address/data hold when idle.
      ram_cs_b   <= tag_p0.valid;
      ram_wren_b <= ack1 && we1;
      if (tag_p0.valid) begin
        ram_address_b <= ack1 ? addr1 : addr0;
        ram_data_b    <= wdata1;
      end
      tag_p1 <= tag_p0;
      // Stage p1 -> p2: RAM samples the address; its data appears after this edge.
      tag_p2 <= tag_p1;
      // Stage p2 -> return: capture read data for the tagged reader.
      rvalid0 <= ret0;
      rvalid1 <= ret1;
      if (ret0) begin
        rdata0 <= ram_q_b;
      end
      if (ret1) begin
        rdata1 <= ram_q_b;
      end
    end
  end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares port B of the board's dual-port video/system RAM between two requesters: requester 0 is the video scan-out fetcher (read-only, high priority) and requester 1 is the ROM/tape loader and debug DMA (read/write).
- Sits between those clients and the dual-port RAM's port B. The CPU keeps port A exclusively.
- Fixed priority to video, with a starvation limit that guarantees the loader a slot.
- Fully pipelined: up to one accepted access per clock.

Parameters:
- data_width_g, 8, RAM word width; must match the RAM instance.
- addr_width_g, 14, RAM address width; must match the RAM instance.
- max_wait_g, 15, consecutive cycles requester 1 may be pending and refused before it is forced to win; range 1..255.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  video read request; hold with addr0 stable until accepted.
- addr0  in  addr_width_g  video read address.
- ack0  out  1  combinational; access accepted on the edge where req0 && ack0.
- rvalid0  out  1  one-cycle pulse; rdata0 is valid.
- rdata0  out  data_width_g  video read data.
- req1  in  1  loader request.
- we1  in  1  1 = write, 0 = read.
- addr1  in  addr_width_g  loader address.
- wdata1  in  data_width_g  loader write data.
- ack1  out  1  combinational accept, same rule as ack0.
- rvalid1  out  1  one-cycle pulse for loader reads only.
- rdata1  out  data_width_g  loader read data.
- ram_cs_b  out  1  registered; port-B access strobe.
- ram_wren_b  out  1  registered; port-B write enable.
- ram_address_b  out  addr_width_g  registered; port-B address.
- ram_data_b  out  data_width_g  registered; port-B write data.
- ram_q_b  in  data_width_g  port-B read data; the RAM registers it one clock after the address.

Behaviour:
- Clock and reset: one clock; synchronous, active-high reset.
- Grant logic (combinational, forced to 0 while reset=1):
  - force1 = (wait_cnt == max_wait_g).
  - ack1 = req1 && (!req0 || force1).
  - ack0 = req0 && !ack1.
  - At most one ack is high in any cycle.
- Starvation counter wait_cnt, 8 bits:
  - Clears to 0 on reset, when req1 is low, or on the edge where req1 && ack1.
  - Increments while req1 && !ack1; saturates at max_wait_g.
- Issue stage, on acceptance edge E0:
  - ram_cs_b=1; ram_address_b=addr of winner.
  - ram_wren_b = we1 if requester 1 won, else 0.
  - ram_data_b=wdata1 (don't-care for reads).
  - Issue-tag register records the winner and whether it is a read.
  - With no acceptance: ram_cs_b=0 and ram_wren_b=0. Address and data hold their last value.
- RAM stage: the RAM samples at E1 and presents ram_q_b after E1. Tag pipeline stage 2 follows.
- Return stage, at E2:
  - rdataN <= ram_q_b and rvalidN=1 for the tagged reader, for exactly one cycle.
  - rdata holds its value between pulses.
  - Writes generate no rvalid.
- Latency: rvalid is high in the cycle beginning 2 clocks after the acceptance edge. Back-to-back acceptances give back-to-back rvalid pulses in issue order.
- Ordering: port-B accesses are performed strictly in acceptance order. A write followed next cycle by a read of the same address returns the new data.
- Cross-port collisions with the CPU on port A are outside this block's scope.
- Simultaneous requests:
  - req0 && req1 with wait_cnt < max_wait_g: video wins.
  - At wait_cnt == max_wait_g: loader wins for exactly that one access, then the counter clears.
- Reset values: ram_cs_b, ram_wren_b, ram_address_b, ram_data_b, rvalid0/1, rdata0/1, wait_cnt and all tag valids = 0.
- Reset mid-operation: all in-flight accesses are discarded. No rvalid is emitted in the first 2 cycles after reset deasserts unless a new access is accepted.

Decomposition:
- Shared package dpram_arb_pkg holds:
  - typedef requester_t (enum REQ_VIDEO, REQ_LOADER).
  - struct arb_tag_t {valid, is_read, requester_t who}.
  - Localparam defaults for data width 8 and address width 14.
- One sub-module, dpram_arb_grant: the combinational ack logic plus the wait_cnt counter.
- The issue/return pipeline stays in the top module.

Test Plan:
- Video only: req0 held at addr0=0x0000..0x0003 on consecutive cycles, RAM preloaded with 0x11,0x22,0x33,0x44 -> ack0 high 4 cycles; rvalid0 pulses on cycles 2..5 with rdata0 = 0x11,0x22,0x33,0x44.
- Loader write then read: req1 we1=1 addr1=0x1234 wdata1=0xA5, next cycle we1=0 addr1=0x1234 -> ram_wren_b=1 for one cycle; rvalid1 with rdata1=0xA5 two cycles after the read is accepted; no rvalid1 for the write.
- Starvation: req0 and req1 both held continuously with max_wait_g=15 -> ack1 first asserts on the 16th cycle; wait_cnt then clears; the pattern repeats every 16 cycles; ack0 and ack1 are never high together.
- Simultaneous, no starvation: req0 and req1 rise together for 1 cycle then req0 drops -> ack0 in cycle 1, ack1 in cycle 2; rvalid0 and rvalid1 arrive in that order.
- Reset mid-flight: assert reset on the cycle after a read acceptance -> no rvalid at the expected return cycle; all outputs 0 throughout reset; ack0 and ack1 stay 0 while reset=1.
